// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage:
// instruction match patterns, FSM state enum, lane helpers.
package mem_access_pkg;

  localparam logic [31:0] LB  = 32'b?????????????????000?????0000011;
  localparam logic [31:0] LH  = 32'b?????????????????001?????0000011;
  localparam logic [31:0] LW  = 32'b?????????????????010?????0000011;
  localparam logic [31:0] LBU = 32'b?????????????????100?????0000011;
  localparam logic [31:0] LHU = 32'b?????????????????101?????0000011;
  localparam logic [31:0] SB  = 32'b?????????????????000?????0100011;
  localparam logic [31:0] SH  = 32'b?????????????????001?????0100011;
  localparam logic [31:0] SW  = 32'b?????????????????010?????0100011;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } mem_state_e;

  // size is funct3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic [3:0] be_mask(
    input logic [1:0] size,
    input logic [1:0] off
  );
    unique case (size)
      2'b00:   be_mask = 4'b0001 << off;
      2'b01:   be_mask = 4'b0011 << off;
      default: be_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_rep(
    input logic [1:0]  size,
    input logic [31:0] d
  );
    unique case (size)
      2'b00:   wdata_rep = {4{d[7:0]}};
      2'b01:   wdata_rep = {2{d[15:0]}};
      default: wdata_rep = d;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load lane select and extension.
// Ports: rdata_i word, addr_i byte offset, funct3_i load kind, data_o result.
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] sh;
  assign sh = rdata_i >> {addr_i, 3'b000};

  always_comb begin
    data_o = rdata_i;
    unique case (funct3_i)
      3'b000:  data_o = {{24{sh[7]}}, sh[7:0]};
      3'b001:  data_o = {{16{sh[15]}}, sh[15:0]};
      3'b100:  data_o = {24'h0, sh[7:0]};
      3'b101:  data_o = {16'h0, sh[15:0]};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Pipeline memory-access stage: issues loads/stores on a
// req/gnt/rvalid port, aligns load data, emits a writeback packet.
// Inputs: execute packet (valid/instr/rd/alu/store data), dmem gnt/rvalid/rdata.
// Outputs: stall, dmem req/we/addr/be/wdata, writeback packet + misalign flag.
module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] instr_i,
  input  logic [4:0]  sel_rd_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [4:0]  sel_rd_o,
  output logic        wb_en_o,
  output logic [31:0] wb_data_o,
  output logic        misalign_o
);

  mem_state_e  state_q;
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [1:0]  off_q;
  logic [31:0] pinstr_q;
  logic [4:0]  prd_q;
  logic        valid_q, wb_en_q, mis_q;
  logic [31:0] instr_q, wb_data_q;
  logic [4:0]  rd_q;

  logic        is_ld, is_st, is_mem, misal;
  logic [31:0] ld_data;

  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    casez (instr_i)
      LB, LH, LW, LBU, LHU: is_ld = 1'b1;
      SB, SH, SW:           is_st = 1'b1;
      default: ;
    endcase
  end

  assign is_mem = is_ld | is_st;

  always_comb begin
    unique case (instr_i[13:12])
      2'b01:   misal = alu_result_i[0];
      2'b10:   misal = |alu_result_i[1:0];
      default: misal = 1'b0;
    endcase
  end

  load_align u_align (
    .rdata_i  (dmem_rdata_i),
    .addr_i   (off_q),
    .funct3_i (pinstr_q[14:12]),
    .data_o   (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      off_q     <= '0;
      pinstr_q  <= '0;
      prd_q     <= '0;
      valid_q   <= 1'b0;
      instr_q   <= '0;
      rd_q      <= '0;
      wb_en_q   <= 1'b0;
      wb_data_q <= '0;
      mis_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (valid_i) begin
            if (is_mem && !misal) begin
              pinstr_q <= instr_i;
              prd_q    <= sel_rd_i;
              off_q    <= alu_result_i[1:0];
              addr_q   <= {alu_result_i[31:2], 2'b00};
              be_q     <= be_mask(instr_i[13:12],
                                  alu_result_i[1:0]);
              wdata_q  <= wdata_rep(instr_i[13:12],
                                    store_data_i);
              we_q     <= is_st;
              req_q    <= 1'b1;
              state_q  <= REQ;
            end else begin
              // non-memory op, or misaligned one
              valid_q   <= 1'b1;
              instr_q   <= instr_i;
              rd_q      <= sel_rd_i;
              wb_data_q <= alu_result_i;
              mis_q     <= is_mem;
              wb_en_q   <= !is_mem && (sel_rd_i != 5'd0)
                           && (instr_i[6:0] != OP_BRANCH);
            end
          end
        end
        REQ: begin
          if (dmem_gnt_i) begin
            req_q <= 1'b0;
            if (we_q) begin
              valid_q <= 1'b1;
              instr_q <= pinstr_q;
              rd_q    <= prd_q;
              wb_en_q <= 1'b0;
              mis_q   <= 1'b0;
              state_q <= IDLE;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid_i) begin
            valid_q   <= 1'b1;
            instr_q   <= pinstr_q;
            rd_q      <= prd_q;
            wb_data_q <= ld_data;
            wb_en_q   <= (prd_q != 5'd0);
            mis_q     <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_o      = (state_q != IDLE);
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign valid_o      = valid_q;
  assign instr_o      = instr_q;
  assign sel_rd_o     = rd_q;
  assign wb_en_o      = wb_en_q;
  assign wb_data_o    = wb_data_q;
  assign misalign_o   = mis_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: drives execute packets,
// acts as data memory, compares writeback packets against a queue.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] instr_i;
  logic [4:0]  sel_rd_i;
  logic [31:0] alu_result_i;
  logic [31:0] store_data_i;
  logic        stall_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [4:0]  sel_rd_o;
  logic        wb_en_o;
  logic [31:0] wb_data_o;
  logic        misalign_o;

  mem_access dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid_i),
    .instr_i       (instr_i),
    .sel_rd_i      (sel_rd_i),
    .alu_result_i  (alu_result_i),
    .store_data_i  (store_data_i),
    .stall_o       (stall_o),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_be_o     (dmem_be_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .valid_o       (valid_o),
    .instr_o       (instr_o),
    .sel_rd_o      (sel_rd_o),
    .wb_en_o       (wb_en_o),
    .wb_data_o     (wb_data_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        en;
    logic [31:0] data;
    logic        mis;
    logic        cd;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op,
                                     input logic [2:0] f3,
                                     input logic [4:0] rd);
    mk = {12'h0, 5'd1, f3, rd, op};
  endfunction

  localparam logic [6:0] OPL = 7'b0000011;
  localparam logic [6:0] OPS = 7'b0100011;
  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] OPB = 7'b1100011;

  always @(negedge clk) begin
    if (valid_o) begin
      if (q.size() == 0) begin
        chk("extra_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("instr_o", instr_o, e.instr);
        chk("sel_rd_o", {27'h0, sel_rd_o}, {27'h0, e.rd});
        chk("wb_en_o", {31'h0, wb_en_o}, {31'h0, e.en});
        chk("misalign_o", {31'h0, misalign_o}, {31'h0, e.mis});
        if (e.cd) chk("wb_data_o", wb_data_o, e.data);
      end
    end
  end

  // kind: 0 = completes next cycle, 1 = store, 2 = load
  task automatic issue(input logic [31:0] ins,
                       input logic [4:0]  rd,
                       input logic [31:0] alu,
                       input logic [31:0] sd,
                       input int          kind,
                       input int          gd,
                       input int          rvd,
                       input logic [31:0] rdata,
                       input logic [3:0]  xbe,
                       input logic [31:0] xwd,
                       input logic        xen,
                       input logic [31:0] xdata,
                       input logic        xmis);
    exp_t e;
    e.instr = ins; e.rd = rd; e.en = xen;
    e.data = xdata; e.mis = xmis; e.cd = (kind != 1);
    q.push_back(e);
    valid_i = 1'b1; instr_i = ins; sel_rd_i = rd;
    alu_result_i = alu; store_data_i = sd;
    @(posedge clk); #1;
    if (kind != 0) begin
      chk("req", {31'h0, dmem_req_o}, 32'd1);
      chk("stall", {31'h0, stall_o}, 32'd1);
      chk("addr", dmem_addr_o, {alu[31:2], 2'b00});
      chk("be", {28'h0, dmem_be_o}, {28'h0, xbe});
      chk("we", {31'h0, dmem_we_o}, (kind == 1) ? 32'd1 : 32'd0);
      if (kind == 1) chk("wdata", dmem_wdata_o, xwd);
      for (int i = 0; i < gd; i++) begin
        @(posedge clk); #1;
        chk("req_hold", {31'h0, dmem_req_o}, 32'd1);
        chk("stall_req", {31'h0, stall_o}, 32'd1);
      end
      dmem_gnt_i = 1'b1;
      @(posedge clk); #1;
      dmem_gnt_i = 1'b0;
      if (kind == 2) begin
        chk("req_drop", {31'h0, dmem_req_o}, 32'd0);
        chk("stall_wait", {31'h0, stall_o}, 32'd1);
        for (int i = 0; i < rvd; i++) begin
          @(posedge clk); #1;
          chk("stall_wait", {31'h0, stall_o}, 32'd1);
          chk("no_valid", {31'h0, valid_o}, 32'd0);
        end
        dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
        @(posedge clk); #1;
        dmem_rvalid_i = 1'b0;
      end
    end else begin
      chk("no_req", {31'h0, dmem_req_o}, 32'd0);
    end
    valid_i = 1'b0;
    chk("valid_lat", {31'h0, valid_o}, 32'd1);
    chk("stall_end", {31'h0, stall_o}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; instr_i = '0; sel_rd_i = '0;
    alu_result_i = '0; store_data_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'h0, valid_o}, 32'd0);
    chk("rst_req", {31'h0, dmem_req_o}, 32'd0);
    chk("rst_stall", {31'h0, stall_o}, 32'd0);
    chk("rst_wb", wb_data_o, 32'd0);
    chk("rst_be", {28'h0, dmem_be_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ADD x5 = 0x1234
    issue(32'h002082B3, 5'd5, 32'h1234, 0, 0, 0, 0, 0,
          4'h0, 0, 1'b1, 32'h1234, 1'b0);
    // LB 0x103, 2 gnt wait cycles, 1 rvalid wait
    issue(mk(OPL, 3'b000, 5'd6), 5'd6, 32'h103, 0, 2, 2, 1,
          32'h80FF_0000, 4'b1000, 0, 1'b1, 32'hFFFF_FF80, 1'b0);
    issue(mk(OPL, 3'b101, 5'd7), 5'd7, 32'h202, 0, 2, 0, 0,
          32'hBEEF_0000, 4'b1100, 0, 1'b1, 32'h0000_BEEF, 1'b0);
    issue(mk(OPL, 3'b001, 5'd8), 5'd8, 32'h202, 0, 2, 1, 2,
          32'hBEEF_0000, 4'b1100, 0, 1'b1, 32'hFFFF_BEEF, 1'b0);
    issue(mk(OPS, 3'b001, 5'd0), 5'd0, 32'h006, 32'h1234_ABCD,
          1, 1, 0, 0, 4'b1100, 32'hABCD_ABCD, 1'b0, 0, 1'b0);
    // misaligned LW and SH
    issue(mk(OPL, 3'b010, 5'd9), 5'd9, 32'h001, 0, 0, 0, 0, 0,
          4'h0, 0, 1'b0, 32'h001, 1'b1);
    issue(mk(OPS, 3'b001, 5'd0), 5'd0, 32'h003, 0, 0, 0, 0, 0,
          4'h0, 0, 1'b0, 32'h003, 1'b1);
    issue(mk(OPS, 3'b000, 5'd0), 5'd0, 32'h001, 32'h0000_005A,
          1, 0, 0, 0, 4'b0010, 32'h5A5A_5A5A, 1'b0, 0, 1'b0);
    issue(mk(OPS, 3'b010, 5'd0), 5'd0, 32'h008, 32'hCAFE_F00D,
          1, 0, 0, 0, 4'b1111, 32'hCAFE_F00D, 1'b0, 0, 1'b0);
    issue(mk(OPL, 3'b010, 5'd10), 5'd10, 32'h010, 0, 2, 0, 0,
          32'h8765_4321, 4'b1111, 0, 1'b1, 32'h8765_4321, 1'b0);
    issue(mk(OPL, 3'b100, 5'd11), 5'd11, 32'h002, 0, 2, 0, 0,
          32'h00AB_0000, 4'b0100, 0, 1'b1, 32'h0000_00AB, 1'b0);
    // load to x0, ADD to x0, branch: no register write
    issue(mk(OPL, 3'b000, 5'd0), 5'd0, 32'h000, 0, 2, 0, 0,
          32'h0000_0077, 4'b0001, 0, 1'b0, 32'h0000_0077, 1'b0);
    issue(mk(OPR, 3'b000, 5'd0), 5'd0, 32'h55, 0, 0, 0, 0, 0,
          4'h0, 0, 1'b0, 32'h55, 1'b0);
    issue(mk(OPB, 3'b000, 5'd3), 5'd3, 32'h66, 0, 0, 0, 0, 0,
          4'h0, 0, 1'b0, 32'h66, 1'b0);

    // idle with valid_i low: no packet
    @(posedge clk); #1;
    chk("idle_novalid", {31'h0, valid_o}, 32'd0);

    // reset while in WAIT
    valid_i = 1'b1; instr_i = mk(OPL, 3'b010, 5'd4);
    sel_rd_i = 5'd4; alu_result_i = 32'h40;
    @(posedge clk); #1;
    dmem_gnt_i = 1'b1;
    @(posedge clk); #1;
    dmem_gnt_i = 1'b0;
    chk("rst_pre_stall", {31'h0, stall_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_stall", {31'h0, stall_o}, 32'd0);
    chk("rst_mid_req", {31'h0, dmem_req_o}, 32'd0);
    chk("rst_mid_addr", dmem_addr_o, 32'd0);
    chk("rst_mid_instr", instr_o, 32'd0);
    chk("rst_mid_wb", wb_data_o, 32'd0);
    valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dmem_rvalid_i = 1'b0;
    chk("late_rvalid", {31'h0, valid_o}, 32'd0);
    issue(32'h002082B3, 5'd5, 32'h0000_9999, 0, 0, 0, 0, 0,
          4'h0, 0, 1'b1, 32'h0000_9999, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("drain", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
